// File: rtl/ram_param_if.sv
// ram_param_if: single-port RAM access bus with requester and memory views
interface ram_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              en;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] indata;
  logic [DATA_W-1:0] outdata;
  logic              rd_valid;
  logic              busy;
  modport master (output en, rw, addr, indata, input outdata, rd_valid, busy);
  modport slave  (input en, rw, addr, indata, output outdata, rd_valid, busy);
endinterface

// File: rtl/ram_param.sv
// ram_param: parameterised single-port RAM with async/sync read and post-reset zero-fill
module ram_param #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 4,
  parameter int READ_MODE      = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic       clk,
  input logic       rst,
  ram_param_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t            state, state_n;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data;
  logic              rd_pulse;
  logic              busy;
  logic              rd_req;
  logic              wr_req;
  assign busy   = state == CLEAR;
  assign rd_req = bus.en & ~bus.rw & ~busy;
  assign wr_req = bus.en & bus.rw & ~busy;
  // leave CLEAR once the last word has been zeroed
  always_comb begin
    state_n = state;
    if (busy && clr_cnt == '1) state_n = IDLE;
  end
  // state register and clear counter; counter parks at the last word
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      clr_cnt <= '0;
    end else begin
      state <= state_n;
      if (busy && clr_cnt != '1) clr_cnt <= clr_cnt + 1'b1;
    end
  end
  // array write port shared by the clear sequencer and user writes
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (busy) mem[clr_cnt] <= '0;
      else if (wr_req) mem[bus.addr] <= bus.indata;
    end
  end
  // registered read path; writes leave the held data untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_pulse <= 1'b0;
    end else begin
      rd_pulse <= rd_req;
      if (rd_req) rd_data <= mem[bus.addr];
    end
  end
  assign bus.outdata  = (READ_MODE != 0) ? rd_data : (busy ? '0 : mem[bus.addr]);
  assign bus.rd_valid = (READ_MODE != 0) ? rd_pulse : rd_req;
  assign bus.busy     = busy;
endmodule

// File: tb/tb_ram_param.sv
// tb_ram_param: scoreboard bench covering async, sync and no-clear RAM configurations
module tb_ram_param;
  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0]  q8[$];
  logic [15:0] q16[$];
  always #5 clk = ~clk;
  ram_param_if #(.DATA_W(8),  .ADDR_W(4)) ia();
  ram_param_if #(.DATA_W(16), .ADDR_W(8)) ib();
  ram_param_if #(.DATA_W(8),  .ADDR_W(4)) ic();
  ram_param #(.DATA_W(8),  .ADDR_W(4), .READ_MODE(0), .CLEAR_ON_RESET(1)) dut_a (.clk(clk), .rst(rst_a), .bus(ia));
  ram_param #(.DATA_W(16), .ADDR_W(8), .READ_MODE(1), .CLEAR_ON_RESET(1)) dut_b (.clk(clk), .rst(rst_b), .bus(ib));
  ram_param #(.DATA_W(8),  .ADDR_W(4), .READ_MODE(0), .CLEAR_ON_RESET(0)) dut_c (.clk(clk), .rst(rst_c), .bus(ic));

  task automatic idle_all;
    ia.en = 0; ia.rw = 0; ia.addr = '0; ia.indata = '0;
    ib.en = 0; ib.rw = 0; ib.addr = '0; ib.indata = '0;
    ic.en = 0; ic.rw = 0; ic.addr = '0; ic.indata = '0;
  endtask

  // pulse rst_a for one edge, then count negedge samples with busy high
  task automatic pulse_count_a(output int c);
    @(negedge clk); rst_a = 1;
    @(negedge clk); rst_a = 0; #1;
    c = 0;
    while (ia.busy === 1'b1 && c < 100) begin
      c++;
      @(negedge clk); #1;
    end
    ia.en = 0;
  endtask

  task automatic sweep_zero_a(input string tag);
    logic [7:0] e;
    for (int a = 0; a < 16; a++) begin
      @(negedge clk); ia.en = 1; ia.rw = 0; ia.addr = 4'(a);
      q8.push_back(8'h00); #1;
      e = q8.pop_front(); n_chk++;
      if (ia.outdata !== e) begin
        n_fail++; $display("FAIL %s addr=%0d got=%h exp=%h", tag, a, ia.outdata, e);
      end
    end
    @(negedge clk); ia.en = 0;
  endtask

  task automatic test_reset;
    int c;
    @(negedge clk); rst_a = 1;
    @(negedge clk); rst_a = 0; #1;
    n_chk++; if (ia.busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy got=%b exp=1", ia.busy); end
    n_chk++; if (ia.outdata !== 8'h00) begin n_fail++; $display("FAIL reset_outdata got=%h exp=00", ia.outdata); end
    n_chk++; if (ia.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got=%b exp=0", ia.rd_valid); end
    ia.en = 1; ia.rw = 1; ia.addr = 4'd5; ia.indata = 8'hFF;
    c = 0;
    while (ia.busy === 1'b1 && c < 100) begin
      c++;
      @(negedge clk); #1;
    end
    ia.en = 0;
    n_chk++; if (c !== 16) begin n_fail++; $display("FAIL clear_duration got=%0d exp=16", c); end
    sweep_zero_a("clear_lockout_zero");
  endtask

  task automatic test_async_rw;
    logic [7:0] exp_mem [16];
    logic [7:0] e;
    for (int a = 0; a < 16; a++) begin
      @(negedge clk); ia.en = 1; ia.rw = 1; ia.addr = 4'(a);
      ia.indata = 8'($urandom); exp_mem[a] = ia.indata;
    end
    for (int a = 15; a >= 0; a--) begin
      @(negedge clk); ia.rw = 0; ia.addr = 4'(a);
      q8.push_back(exp_mem[a]); #1;
      e = q8.pop_front(); n_chk++;
      if (ia.outdata !== e) begin
        n_fail++; $display("FAIL async_read addr=%0d got=%h exp=%h", a, ia.outdata, e);
      end
      n_chk++;
      if (ia.rd_valid !== 1'b1) begin
        n_fail++; $display("FAIL async_rd_valid addr=%0d got=%b exp=1", a, ia.rd_valid);
      end
    end
    @(negedge clk); ia.en = 0; ia.addr = 4'd3; q8.push_back(exp_mem[3]); #1;
    e = q8.pop_front(); n_chk++;
    if (ia.outdata !== e) begin n_fail++; $display("FAIL async_no_en got=%h exp=%h", ia.outdata, e); end
    n_chk++;
    if (ia.rd_valid !== 1'b0) begin n_fail++; $display("FAIL async_no_en_valid got=%b exp=0", ia.rd_valid); end
  endtask

  task automatic test_reset_mid_clear;
    int c;
    @(negedge clk); rst_a = 1;
    @(negedge clk); rst_a = 0;
    ia.en = 1; ia.rw = 0; ia.addr = 4'd1;
    repeat (7) @(negedge clk);
    #1;
    n_chk++;
    if (ia.rd_valid !== 1'b0) begin n_fail++; $display("FAIL busy_read_valid got=%b exp=0", ia.rd_valid); end
    ia.en = 0;
    pulse_count_a(c);
    n_chk++; if (c !== 16) begin n_fail++; $display("FAIL restart_duration got=%0d exp=16", c); end
    sweep_zero_a("restart_zero");
  endtask

  task automatic test_sync;
    int c;
    logic [15:0] e;
    @(negedge clk); rst_b = 1;
    @(negedge clk); rst_b = 0; #1;
    n_chk++; if (ib.outdata !== 16'h0 || ib.rd_valid !== 1'b0 || ib.busy !== 1'b1) begin
      n_fail++; $display("FAIL sync_reset out=%h valid=%b busy=%b exp=0000/0/1", ib.outdata, ib.rd_valid, ib.busy);
    end
    c = 0;
    while (ib.busy === 1'b1 && c < 400) begin c++; @(negedge clk); #1; end
    n_chk++; if (c !== 256) begin n_fail++; $display("FAIL sync_clear_duration got=%0d exp=256", c); end
    ib.en = 1; ib.rw = 1; ib.addr = 8'h3C; ib.indata = 16'hA5A5;
    @(negedge clk); ib.rw = 0; q16.push_back(16'hA5A5);
    @(negedge clk); ib.en = 0; #1;
    n_chk++; if (ib.rd_valid !== 1'b1) begin n_fail++; $display("FAIL sync_valid got=%b exp=1", ib.rd_valid); end
    e = q16.pop_front(); n_chk++;
    if (ib.outdata !== e) begin n_fail++; $display("FAIL sync_read got=%h exp=%h", ib.outdata, e); end
    @(negedge clk); ib.en = 1; ib.rw = 1; ib.indata = 16'h1234; #1;
    n_chk++; if (ib.rd_valid !== 1'b0) begin n_fail++; $display("FAIL sync_single_pulse got=%b exp=0", ib.rd_valid); end
    @(negedge clk); ib.en = 0; #1;
    n_chk++; if (ib.outdata !== 16'hA5A5 || ib.rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL sync_write_hold out=%h valid=%b exp=a5a5/0", ib.outdata, ib.rd_valid);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); ib.en = 1; ib.rw = 1; ib.addr = 8'(16 + i); ib.indata = 16'(16'h1000 + i * 16'h0111);
    end
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk); #1;
      if (i > 0) begin
        n_chk++;
        if (ib.rd_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid i=%0d got=%b exp=1", i, ib.rd_valid); end
        e = q16.pop_front(); n_chk++;
        if (ib.outdata !== e) begin n_fail++; $display("FAIL b2b_read i=%0d got=%h exp=%h", i, ib.outdata, e); end
      end
      if (i < 4) begin
        ib.en = 1; ib.rw = 0; ib.addr = 8'(16 + i); q16.push_back(16'(16'h1000 + i * 16'h0111));
      end else ib.en = 0;
    end
    @(negedge clk); #1;
    n_chk++; if (ib.rd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end_valid got=%b exp=0", ib.rd_valid); end
    ib.en = 1; ib.rw = 0; ib.addr = 8'h3C;
    @(negedge clk); ib.en = 0; rst_b = 1;
    @(negedge clk); rst_b = 0; #1;
    n_chk++; if (ib.rd_valid !== 1'b0 || ib.outdata !== 16'h0) begin
      n_fail++; $display("FAIL sync_inflight_reset out=%h valid=%b exp=0000/0", ib.outdata, ib.rd_valid);
    end
  endtask

  task automatic test_no_clear;
    logic [7:0] e;
    @(negedge clk); ic.en = 1; ic.rw = 1; ic.addr = 4'd2; ic.indata = 8'h5A;
    @(negedge clk); ic.en = 0; rst_c = 1; #1;
    n_chk++; if (ic.busy !== 1'b0) begin n_fail++; $display("FAIL noclr_busy_in_rst got=%b exp=0", ic.busy); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); rst_c = 0; #1;
      n_chk++; if (ic.busy !== 1'b0) begin n_fail++; $display("FAIL noclr_busy i=%0d got=%b exp=0", i, ic.busy); end
    end
    ic.en = 1; ic.rw = 0; ic.addr = 4'd2; q8.push_back(8'h5A); #1;
    e = q8.pop_front(); n_chk++;
    if (ic.outdata !== e) begin n_fail++; $display("FAIL noclr_retain got=%h exp=%h", ic.outdata, e); end
    @(negedge clk); ic.en = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_all();
    rst_a = 1; rst_b = 1; rst_c = 1;
    repeat (2) @(negedge clk);
    rst_a = 0; rst_b = 0; rst_c = 0;
    test_reset();
    test_async_rw();
    test_reset_mid_clear();
    test_sync();
    test_no_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
